// File: rtl/main_decoder_pipe.sv
// Pipelined main decoder: combinational extend/regfile selects plus a registered ID/EX
// control bundle with valid/ready, stall/flush, illegal-op flagging and multi-cycle MUL occupancy.
module main_decoder_pipe #(
  parameter int ENABLE_MUL  = 1,
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] MulBits,
  input  logic       stall_e,
  input  logic       flush_e,
  output logic       id_ready,
  output logic [1:0] ImmSrcD,
  output logic [1:0] RegSrcD,
  output logic       BranchE,
  output logic       RegWE,
  output logic       MemWE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic       ALUOpE,
  output logic       MulE,
  output logic       ValidE,
  output logic       IllegalE,
  output logic       mul_busy
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  typedef struct packed {
    logic branch;
    logic mem_to_reg;
    logic mem_w;
    logic alu_src;
    logic reg_w;
    logic alu_op;
    logic mul;
    logic valid;
    logic illegal;
  } ctrl_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  ctrl_t              ctrl_reg, ctrl_next;
  ctrl_t              dec;
  logic               is_mul;
  logic               accept;
  logic               unused_funct;

  // Funct[3:1] only matter to the ALU decoder, not to the main decoder.
  assign unused_funct = ^Funct[3:1];

  assign is_mul   = (ENABLE_MUL != 0) && (Op == 2'b00) && (Funct[5:4] == 2'b00) && (MulBits == 4'b1001);
  assign id_ready = (state_reg == IDLE) && !stall_e;
  assign accept   = id_valid && id_ready;
  assign mul_busy = (state_reg == MUL_BUSY);

  always_comb begin
    dec     = '0;
    ImmSrcD = 2'b00;
    RegSrcD = 2'b00;
    case (Op)
      2'b00: begin
        dec.reg_w   = 1'b1;
        dec.alu_src = Funct[5];
        dec.alu_op  = !is_mul;
        dec.mul     = is_mul;
      end
      2'b01: begin
        dec.alu_src = 1'b1;
        ImmSrcD     = 2'b01;
        if (Funct[0]) begin
          dec.mem_to_reg = 1'b1;
          dec.reg_w      = 1'b1;
        end else begin
          dec.mem_w = 1'b1;
          RegSrcD   = 2'b10;
        end
      end
      2'b10: begin
        dec.branch  = 1'b1;
        dec.alu_src = 1'b1;
        ImmSrcD     = 2'b10;
        RegSrcD     = 2'b01;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid = 1'b1;
  end

  // Priority: flush > stall > accept/bubble in IDLE > hold while MUL occupies ID/EX.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ctrl_next  = ctrl_reg;
    if (flush_e) begin
      state_next = IDLE;
      cnt_next   = '0;
      ctrl_next  = '0;
    end else if (!stall_e) begin
      if (state_reg == IDLE) begin
        ctrl_next = accept ? dec : '0;
        if (accept && dec.mul && (MUL_LATENCY > 1)) begin
          state_next = MUL_BUSY;
          cnt_next   = CNT_W'(MUL_LATENCY - 1);
        end
      end else if (cnt_reg <= CNT_W'(1)) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ctrl_reg  <= ctrl_next;
    end
  end

  assign BranchE   = ctrl_reg.branch;
  assign MemtoRegE = ctrl_reg.mem_to_reg;
  assign MemWE     = ctrl_reg.mem_w;
  assign ALUSrcE   = ctrl_reg.alu_src;
  assign RegWE     = ctrl_reg.reg_w;
  assign ALUOpE    = ctrl_reg.alu_op;
  assign MulE      = ctrl_reg.mul;
  assign ValidE    = ctrl_reg.valid;
  assign IllegalE  = ctrl_reg.illegal;

endmodule
